// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution slice.
package branch_pkg;

  typedef enum logic [2:0] {
    BEQ  = 3'b000,
    BNE  = 3'b001,
    BLT  = 3'b100,
    BGE  = 3'b101,
    BLTU = 3'b110,
    BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    IDLE,
    HOLD
  } br_state_e;

  localparam int unsigned PC_STEP = 4;

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition decode from comparator flags and funct3.
module branch_cond
  import branch_pkg::*;
(
  input  logic [2:0] funct3_i,
  input  logic       br_eq_i,
  input  logic       br_lt_i,
  input  logic       a_msb_i,
  input  logic       b_msb_i,
  output logic       cond_o,
  output logic       illegal_o
);

  logic slt;

  // Differing sign bits settle a signed compare; equal signs fall back to the unsigned flag.
  assign slt = (a_msb_i != b_msb_i) ? a_msb_i : br_lt_i;

  always_comb begin
    cond_o    = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      BEQ:     cond_o = br_eq_i;
      BNE:     cond_o = ~br_eq_i;
      BLT:     cond_o = slt;
      BGE:     cond_o = ~slt;
      BLTU:    cond_o = br_lt_i;
      BGEU:    cond_o = ~br_lt_i;
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolver.sv
// Branch resolver with a single-entry result buffer on a valid/ready handshake.
// Optional statistics counters are enabled by defining BRANCH_RESOLVER_STATS_EN.
module branch_resolver
  import branch_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             br_eq,
  input  logic             br_lt,
  input  logic             a_msb,
  input  logic             b_msb,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             taken,
  output logic [XLEN-1:0]  target,
  output logic             illegal,
  output logic             misalign
`ifdef BRANCH_RESOLVER_STATS_EN
  ,
  output logic [CNT_W-1:0] cnt_taken,
  output logic [CNT_W-1:0] cnt_not_taken,
  output logic [CNT_W-1:0] cnt_illegal
`endif
);

  br_state_e       state_q, state_d;
  logic            accept;
  logic            condNow, illegalNow, takenNow, misalignNow;
  logic [XLEN-1:0] branchTgt, seqTgt, targetNow;
  logic            taken_q, illegal_q, misalign_q;
  logic [XLEN-1:0] target_q;

  assign req_ready = (state_q == IDLE) | res_ready;
  assign accept    = req_valid & req_ready;

  branch_cond u_cond (
    .funct3_i  (funct3),
    .br_eq_i   (br_eq),
    .br_lt_i   (br_lt),
    .a_msb_i   (a_msb),
    .b_msb_i   (b_msb),
    .cond_o    (condNow),
    .illegal_o (illegalNow)
  );

  assign branchTgt   = pc + imm;
  assign seqTgt      = pc + XLEN'(PC_STEP);
  assign misalignNow = condNow & branchTgt[1];
  assign takenNow    = condNow & ~branchTgt[1];
  // Misaligned branches fall through to pc + 4 rather than redirecting.
  assign targetNow   = takenNow ? (branchTgt & ~XLEN'(1)) : seqTgt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = HOLD;
      HOLD:    if (res_ready && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
    end else if (accept) begin
      taken_q    <= takenNow;
      illegal_q  <= illegalNow;
      misalign_q <= misalignNow;
      target_q   <= targetNow;
    end
  end

  assign res_valid = (state_q == HOLD);
  assign taken     = taken_q;
  assign illegal   = illegal_q;
  assign misalign  = misalign_q;
  assign target    = target_q;

`ifdef BRANCH_RESOLVER_STATS_EN
  logic [CNT_W-1:0] cntTaken_q, cntTaken_d;
  logic [CNT_W-1:0] cntNotTaken_q, cntNotTaken_d;
  logic [CNT_W-1:0] cntIllegal_q, cntIllegal_d;

  // Illegal requests count only as illegal; misaligned ones count as not-taken.
  always_comb begin
    cntTaken_d    = cntTaken_q;
    cntNotTaken_d = cntNotTaken_q;
    cntIllegal_d  = cntIllegal_q;
    if (accept) begin
      if (illegalNow) begin
        cntIllegal_d = cntIllegal_q + CNT_W'(1);
      end else if (takenNow) begin
        cntTaken_d = cntTaken_q + CNT_W'(1);
      end else begin
        cntNotTaken_d = cntNotTaken_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cntTaken_q    <= '0;
      cntNotTaken_q <= '0;
      cntIllegal_q  <= '0;
    end else begin
      cntTaken_q    <= cntTaken_d;
      cntNotTaken_q <= cntNotTaken_d;
      cntIllegal_q  <= cntIllegal_d;
    end
  end

  assign cnt_taken     = cntTaken_q;
  assign cnt_not_taken = cntNotTaken_q;
  assign cnt_illegal   = cntIllegal_q;
`else
  if (CNT_W == 0) begin : g_cnt_w_check
    $error("branch_resolver: CNT_W must be nonzero");
  end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Randomized scoreboard bench for branch_resolver; checks counters when BRANCH_RESOLVER_STATS_EN is defined.
module tb_branch_resolver;

   typedef struct packed {
      logic        taken;
      logic [31:0] target;
      logic        illegal;
      logic        misalign;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] pc = '0;
   logic [31:0] imm = '0;
   logic [31:0] opA = '0;
   logic [31:0] opB = '0;
   logic        br_eq, br_lt, a_msb, b_msb;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic        taken;
   logic [31:0] target;
   logic        illegal;
   logic        misalign;
`ifdef BRANCH_RESOLVER_STATS_EN
   logic [31:0] cnt_taken, cnt_not_taken, cnt_illegal;
   int          expTaken = 0, expNotTaken = 0, expIllegal = 0;
`endif

   int   checks = 0;
   int   errors = 0;
   bit   randReady = 1'b0;
   exp_t scoreQ[$];

   // Comparator flags are derived from real operands so the model can reason about values.
   assign br_eq = (opA == opB);
   assign br_lt = (opA < opB);
   assign a_msb = opA[31];
   assign b_msb = opB[31];

   branch_resolver #(.XLEN(32), .CNT_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .funct3    (funct3),
      .pc        (pc),
      .imm       (imm),
      .br_eq     (br_eq),
      .br_lt     (br_lt),
      .a_msb     (a_msb),
      .b_msb     (b_msb),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .taken     (taken),
      .target    (target),
      .illegal   (illegal),
      .misalign  (misalign)
`ifdef BRANCH_RESOLVER_STATS_EN
      ,
      .cnt_taken     (cnt_taken),
      .cnt_not_taken (cnt_not_taken),
      .cnt_illegal   (cnt_illegal)
`endif
   );

   always #5 clk = ~clk;

   // Reference model: branch semantics from full operand values.
   function automatic exp_t refModel(input logic [2:0] f, input logic [31:0] p,
                                     input logic [31:0] im, input logic [31:0] a,
                                     input logic [31:0] b);
      exp_t        r;
      bit          c;
      logic [31:0] t;
      r.illegal = 1'b0;
      case (f)
         3'd0:    c = (a == b);
         3'd1:    c = (a != b);
         3'd4:    c = ($signed(a) < $signed(b));
         3'd5:    c = ($signed(a) >= $signed(b));
         3'd6:    c = (a < b);
         3'd7:    c = (a >= b);
         default: begin c = 1'b0; r.illegal = 1'b1; end
      endcase
      t = p + im;
      r.misalign = c && (t[1] == 1'b1);
      r.taken    = c && !r.misalign;
      r.target   = r.taken ? {t[31:1], 1'b0} : p + 32'd4;
      return r;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Monitor: compares the buffered result against the scoreboard head, then records new accepts.
   always @(negedge clk) begin
      if (!rst) begin
         checkOutput("req_ready", 32'(req_ready), 32'((scoreQ.size() == 0) || res_ready));
         if (scoreQ.size() != 0) begin
            checkOutput("res_valid", 32'(res_valid), 32'd1);
            if (res_valid) begin
               checkOutput("taken", 32'(taken), 32'(scoreQ[0].taken));
               checkOutput("target", target, scoreQ[0].target);
               checkOutput("illegal", 32'(illegal), 32'(scoreQ[0].illegal));
               checkOutput("misalign", 32'(misalign), 32'(scoreQ[0].misalign));
               if (res_ready) void'(scoreQ.pop_front());
            end
         end else if (res_valid) begin
            checkOutput("spurious_res_valid", 32'(res_valid), 32'd0);
         end
         if (req_valid && req_ready) begin
            exp_t e;
            e = refModel(funct3, pc, imm, opA, opB);
            scoreQ.push_back(e);
`ifdef BRANCH_RESOLVER_STATS_EN
            if (e.illegal) expIllegal++;
            else if (e.taken) expTaken++;
            else expNotTaken++;
`endif
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      if (randReady) res_ready = ($urandom_range(0, 3) != 0);
   endtask

   // Presents one request and waits (bounded) for it to be accepted.
   task automatic applyStimulus(input logic [2:0] f, input logic [31:0] p, input logic [31:0] im,
                                input logic [31:0] a, input logic [31:0] b);
      bit acc;
      funct3 = f; pc = p; imm = im; opA = a; opB = b;
      req_valid = 1'b1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         acc = req_ready;
         tick();
         if (acc) begin
            req_valid = 1'b0;
            return;
         end
      end
      checkOutput("accept_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("[TB] FAIL global_timeout: got timeout, expected finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      #12;
      checkOutput("rst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("rst_taken", 32'(taken), 32'd0);
      checkOutput("rst_target", target, 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_misalign", 32'(misalign), 32'd0);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1; rst = 1'b0;
      res_ready = 1'b1;

      // Directed cases
      applyStimulus(3'b100, 32'h100, 32'h20, 32'h8000_0000, 32'h1);
      applyStimulus(3'b111, 32'h200, 32'h40, 32'h1, 32'h2);
      applyStimulus(3'b000, 32'h200, 32'hFFFF_FFF0, 32'h55, 32'h55);
      applyStimulus(3'b010, 32'h300, 32'h10, 32'h1, 32'h1);
      applyStimulus(3'b000, 32'h100, 32'h6, 32'h7, 32'h7);
      applyStimulus(3'b001, 32'hFFFF_FFFC, 32'h10, 32'h9, 32'h9);
      applyStimulus(3'b000, 32'hFFFF_FFF0, 32'h20, 32'h3, 32'h3);

      // Backpressure: second request must wait while the first result is held
      tick();
      res_ready = 1'b0;
      applyStimulus(3'b110, 32'h400, 32'h8, 32'h1, 32'h2);
      funct3 = 3'b101; pc = 32'h500; imm = 32'h10; opA = 32'h5; opB = 32'h3;
      req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
         @(posedge clk); #1;
      end
      res_ready = 1'b1;
      @(negedge clk);
      checkOutput("bp_release_ready", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
      res_ready = 1'b0;
      @(negedge clk);
      checkOutput("bp_b2b_valid", 32'(res_valid), 32'd1);
      @(posedge clk); #1;
      res_ready = 1'b1;
      tick();

      // Randomized traffic with random consumer stalls
      randReady = 1'b1;
      for (int n = 0; n < 300; n++) begin
         logic [31:0] a, b, p, im;
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? a : $urandom;
         if ($urandom_range(0, 3) == 0) b[31] = a[31];
         p  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         im = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
         applyStimulus(3'($urandom_range(0, 7)), p, im, a, b);
         if ($urandom_range(0, 3) == 0) begin
            repeat ($urandom_range(1, 3)) tick();
         end
      end

      // Drain the buffer
      randReady = 1'b0;
      res_ready = 1'b1;
      for (int i = 0; i < 20 && scoreQ.size() != 0; i++) tick();
      checkOutput("drain_empty", 32'(scoreQ.size()), 32'd0);

`ifdef BRANCH_RESOLVER_STATS_EN
      @(negedge clk);
      checkOutput("cnt_taken", cnt_taken, 32'(expTaken));
      checkOutput("cnt_not_taken", cnt_not_taken, 32'(expNotTaken));
      checkOutput("cnt_illegal", cnt_illegal, 32'(expIllegal));
`endif

      // Asynchronous reset while a result is held
      res_ready = 1'b0;
      applyStimulus(3'b000, 32'h600, 32'h20, 32'h1, 32'h1);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      checkOutput("arst_res_valid", 32'(res_valid), 32'd0);
      checkOutput("arst_taken", 32'(taken), 32'd0);
      checkOutput("arst_target", target, 32'd0);
      checkOutput("arst_req_ready", 32'(req_ready), 32'd1);
`ifdef BRANCH_RESOLVER_STATS_EN
      checkOutput("arst_cnt_taken", cnt_taken, 32'd0);
      expTaken = 0; expNotTaken = 0; expIllegal = 0;
`endif
      scoreQ.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_idle", 32'(res_valid), 32'd0);
      checkOutput("post_rst_ready", 32'(req_ready), 32'd1);

`ifdef BRANCH_RESOLVER_STATS_EN
      res_ready = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(3'b000, 32'h1000, 32'h40, 32'h2, 32'h2);
      for (int i = 0; i < 2; i++) applyStimulus(3'b011, 32'h1000, 32'h40, 32'h2, 32'h2);
      tick();
      @(negedge clk);
      checkOutput("stats_taken", cnt_taken, 32'd5);
      checkOutput("stats_illegal", cnt_illegal, 32'd2);
      checkOutput("stats_not_taken", cnt_not_taken, 32'd0);
`endif

      tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
